// File: rtl/unified_buffer_vec.sv
// -----------------------------------------------------------------------------
// unified_buffer_vec
//
// On-chip activation/result store between the accumulators (store side) and
// the input-setup buffer (load side). Holds DEPTH words of DATA_W bits and
// moves whole N x N tiles per handshake.
//
// Stores are drained into memory one row (N words) per cycle, giving a fixed
// N-cycle busy window after every accepted store. After reset the whole memory
// is zeroed by a sweep of one row per cycle. Tile accesses that would run past
// the end of memory are rejected and flagged with a one-cycle error pulse.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// the request (i_wr_valid / i_rd_req) and the matching ready (o_wr_ready /
// o_rd_ready) are both high. Ready never depends on anything but the current
// state and, for the load side, i_wr_valid (a store wins a simultaneous load).
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous, active-high reset
//   i_wr_valid   tile store request
//   o_wr_ready   store can be accepted (IDLE only)
//   i_wr_addr    base word address of the stored tile
//   i_wr_data    tile, word k at [k*DATA_W +: DATA_W], k = row*N + col
//   i_rd_req     tile load request
//   o_rd_ready   load can be accepted (IDLE and no store request)
//   i_rd_addr    base word address of the loaded tile
//   o_rd_valid   one-cycle pulse, o_rd_data holds the requested tile
//   o_rd_data    loaded tile, same packing as i_wr_data; held until next load
//   o_err        one-cycle pulse after an accepted out-of-range access
//   o_busy       high while clearing or draining a store
//   o_dbg_state  current FSM state (0 CLEAR, 1 IDLE, 2 STORE)
// -----------------------------------------------------------------------------
module unified_buffer_vec #(
    parameter int DATA_W = 32,
    parameter int N      = 2,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [N*N*DATA_W-1:0] i_wr_data,
    input  logic                  i_rd_req,
    output logic                  o_rd_ready,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic                  o_rd_valid,
    output logic [N*N*DATA_W-1:0] o_rd_data,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [1:0]            o_dbg_state
);

    localparam int TILE   = N * N;
    localparam int TILE_W = TILE * DATA_W;
    localparam int ROW_BW = N * DATA_W;
    localparam int ROWS   = DEPTH / N;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Range checks are done one bit wider than the address so that
    // base + tile size can never wrap back into range.
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   TILE_A   = (ADDR_W + 1)'(TILE);
    localparam logic [ROW_W-1:0]  LAST_CLR = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  LAST_ST  = ROW_W'(N - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ROW_W-1:0]    r_row;
    logic [ADDR_W-1:0]   r_base;
    logic [TILE_W-1:0]   r_tile;
    logic                r_rd_valid;
    logic [TILE_W-1:0]   r_rd_data;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_ready;
    logic                w_rd_ready;
    logic                w_busy;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDR_W:0]     w_wr_end;
    logic [ADDR_W:0]     w_rd_end;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic [TILE_W-1:0]   w_rd_tile;
    logic [ADDR_W-1:0]   w_row_off;
    logic [ADDR_W-1:0]   w_row_base;
    logic [ROW_BW-1:0]   w_row_wdata;
    logic                w_mem_we;

    // ------------------------------------------------------------------
    // Handshake qualification and range checks
    // ------------------------------------------------------------------
    assign w_wr_end = {1'b0, i_wr_addr} + TILE_A;
    assign w_rd_end = {1'b0, i_rd_addr} + TILE_A;
    assign w_wr_ok  = (w_wr_end <= LIMIT);
    assign w_rd_ok  = (w_rd_end <= LIMIT);
    assign w_wr_acc = i_wr_valid && w_wr_ready;
    assign w_rd_acc = i_rd_req && w_rd_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wr_ready   = 1'b0;
        w_rd_ready   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_CLEAR: begin
                if (r_row == LAST_CLR) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                w_wr_ready = 1'b1;
                w_rd_ready = !i_wr_valid;
                w_busy     = 1'b0;
                // A rejected (out-of-range) store leaves the FSM in IDLE.
                if (w_wr_acc && w_wr_ok) begin
                    w_next_state = S_STORE;
                end
            end
            S_STORE: begin
                if (r_row == LAST_ST) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row write path shared by the clear sweep and the store drain
    // ------------------------------------------------------------------
    assign w_mem_we  = (r_state == S_CLEAR) || (r_state == S_STORE);
    assign w_row_off = ADDR_W'(r_row) * ADDR_W'(N);

    always_comb begin
        w_row_base  = w_row_off;
        w_row_wdata = '0;
        if (r_state == S_STORE) begin
            w_row_base = r_base + w_row_off;
            for (int r = 0; r < N; r++) begin
                if (r_row == ROW_W'(r)) begin
                    w_row_wdata = r_tile[r*ROW_BW +: ROW_BW];
                end
            end
        end
    end

    // Memory has no reset of its own: the clear sweep zeroes it. Nothing is
    // written during a reset cycle, which discards a store in flight.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_mem_we) begin
            for (int c = 0; c < N; c++) begin
                r_mem[w_row_base + ADDR_W'(c)] <= w_row_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tile read: gathered from memory combinationally, captured on accept.
    // Out-of-range loads return zeros.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_tile = '0;
        if (w_rd_ok) begin
            for (int k = 0; k < TILE; k++) begin
                w_rd_tile[k*DATA_W +: DATA_W] = r_mem[i_rd_addr + ADDR_W'(k)];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row      <= '0;
            r_base     <= '0;
            r_tile     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            // Store and load are never accepted in the same cycle.
            r_err      <= (w_wr_acc && !w_wr_ok) || (w_rd_acc && !w_rd_ok);

            if (w_rd_acc) begin
                r_rd_data <= w_rd_tile;
            end

            if (w_wr_acc && w_wr_ok) begin
                r_base <= i_wr_addr;
                r_tile <= i_wr_data;
            end

            case (r_state)
                S_CLEAR: r_row <= (r_row == LAST_CLR) ? '0 : r_row + 1'b1;
                S_STORE: r_row <= (r_row == LAST_ST)  ? '0 : r_row + 1'b1;
                default: r_row <= '0;
            endcase
        end
    end

    assign o_wr_ready  = w_wr_ready;
    assign o_rd_ready  = w_rd_ready;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_err       = r_err;
    assign o_busy      = w_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_unified_buffer_vec.sv
// -----------------------------------------------------------------------------
// tb_unified_buffer_vec
//
// Directed bench for unified_buffer_vec with default parameters
// (DATA_W 32, N 2, DEPTH 64). Inputs change and outputs are sampled 1 ns
// after each rising edge; combinational readies are sampled after a further
// 1 ns settle once the inputs for the cycle are applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unified_buffer_vec;

    localparam int DATA_W = 32;
    localparam int N      = 2;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int TILE_W = N * N * DATA_W;

    logic              clk;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [TILE_W-1:0] wr_data;
    logic              rd_req;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [TILE_W-1:0] rd_data;
    logic              err;
    logic              busy;
    logic [1:0]        dbg_state;

    int n_checks;
    int n_errors;

    unified_buffer_vec #(
        .DATA_W (DATA_W),
        .N      (N),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_req    (rd_req),
        .o_rd_ready  (rd_ready),
        .i_rd_addr   (rd_addr),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_err       (err),
        .o_busy      (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [TILE_W-1:0] got,
                         input logic [TILE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TILE_W-1:0] mk_tile(input int w0, input int w1,
                                                  input int w2, input int w3);
        return {DATA_W'(w3), DATA_W'(w2), DATA_W'(w1), DATA_W'(w0)};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until wr_ready rises, bounded.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!wr_ready && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // Store a valid tile and wait out its drain window.
    task automatic do_store(input logic [ADDR_W-1:0] a, input logic [TILE_W-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [TILE_W-1:0] exp, input logic exp_err);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check({tag, "_valid"}, TILE_W'(rd_valid), TILE_W'(1));
        check({tag, "_data"},  rd_data, exp);
        check({tag, "_err"},   TILE_W'(err), TILE_W'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        logic [TILE_W-1:0] t1, t2, t3, t4, t5, t6;
        t1 = mk_tile(11, 12, 21, 22);
        t2 = mk_tile(101, 102, 103, 104);
        t3 = mk_tile(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        t4 = mk_tile(1, 2, 3, 4);
        t5 = mk_tile(5, 6, 7, 8);
        t6 = mk_tile(32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D);

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        tick();
        tick();

        // Reset values
        check("rst_wr_ready", TILE_W'(wr_ready), TILE_W'(0));
        check("rst_rd_ready", TILE_W'(rd_ready), TILE_W'(0));
        check("rst_rd_valid", TILE_W'(rd_valid), TILE_W'(0));
        check("rst_rd_data",  rd_data, '0);
        check("rst_err",      TILE_W'(err), TILE_W'(0));
        check("rst_busy",     TILE_W'(busy), TILE_W'(1));

        // Clear sweep length
        reset = 1'b0;
        wait_ready(cyc);
        check("clear_cycles", TILE_W'(cyc), TILE_W'(32));
        check("idle_busy", TILE_W'(busy), TILE_W'(0));

        // Zeroed memory, rd_valid is a single pulse
        #1;
        check("idle_rd_ready", TILE_W'(rd_ready), TILE_W'(1));
        do_read("rd0", 6'd0, '0, 1'b0);
        tick();
        check("rd0_pulse_end", TILE_W'(rd_valid), TILE_W'(0));

        // Store at 30: two-cycle busy window, then coherent read
        wr_valid = 1'b1;
        wr_addr  = 6'd30;
        wr_data  = t1;
        tick();
        wr_valid = 1'b0;
        check("st_ready_lo1", TILE_W'(wr_ready), TILE_W'(0));
        check("st_busy1",     TILE_W'(busy), TILE_W'(1));
        tick();
        check("st_ready_lo2", TILE_W'(wr_ready), TILE_W'(0));
        check("st_busy2",     TILE_W'(busy), TILE_W'(1));
        tick();
        check("st_ready_hi",  TILE_W'(wr_ready), TILE_W'(1));
        do_read("raw30", 6'd30, t1, 1'b0);

        // Simultaneous store and load: store wins, load follows 3 edges later
        wr_valid = 1'b1;
        wr_addr  = 6'd8;
        wr_data  = t2;
        rd_req   = 1'b1;
        rd_addr  = 6'd8;
        #1;
        check("sim_rd_ready", TILE_W'(rd_ready), TILE_W'(0));
        check("sim_wr_ready", TILE_W'(wr_ready), TILE_W'(1));
        tick();
        wr_valid = 1'b0;
        check("sim_rv0", TILE_W'(rd_valid), TILE_W'(0));
        tick();
        check("sim_rv1", TILE_W'(rd_valid), TILE_W'(0));
        tick();
        check("sim_rv2", TILE_W'(rd_valid), TILE_W'(0));
        tick();
        rd_req = 1'b0;
        check("sim_rv3",   TILE_W'(rd_valid), TILE_W'(1));
        check("sim_data",  rd_data, t2);

        // Out-of-range store and load
        do_store(6'd60, t3);
        wr_valid = 1'b1;
        wr_addr  = 6'd62;
        wr_data  = t6;
        tick();
        wr_valid = 1'b0;
        check("oob_wr_err",   TILE_W'(err), TILE_W'(1));
        check("oob_wr_busy",  TILE_W'(busy), TILE_W'(0));
        check("oob_wr_ready", TILE_W'(wr_ready), TILE_W'(1));
        tick();
        check("oob_wr_err_end", TILE_W'(err), TILE_W'(0));
        do_read("oob_rd61", 6'd61, '0, 1'b1);
        tick();
        check("oob_rd_err_end", TILE_W'(err), TILE_W'(0));
        do_read("rd60", 6'd60, t3, 1'b0);

        // Back-to-back loads at 0, 4, 8
        do_store(6'd0, t4);
        do_store(6'd4, t5);
        rd_req  = 1'b1;
        rd_addr = 6'd0;
        tick();
        rd_addr = 6'd4;
        check("b2b0_valid", TILE_W'(rd_valid), TILE_W'(1));
        check("b2b0_data",  rd_data, t4);
        tick();
        rd_addr = 6'd8;
        check("b2b1_valid", TILE_W'(rd_valid), TILE_W'(1));
        check("b2b1_data",  rd_data, t5);
        tick();
        rd_req = 1'b0;
        check("b2b2_valid", TILE_W'(rd_valid), TILE_W'(1));
        check("b2b2_data",  rd_data, t2);
        tick();
        check("b2b_end", TILE_W'(rd_valid), TILE_W'(0));

        // Reset in the second STORE cycle discards the store
        wr_valid = 1'b1;
        wr_addr  = 6'd16;
        wr_data  = t6;
        tick();
        wr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_st_busy",  TILE_W'(busy), TILE_W'(1));
        check("rst_st_ready", TILE_W'(wr_ready), TILE_W'(0));
        check("rst_st_rdata", rd_data, '0);
        reset = 1'b0;
        wait_ready(cyc);
        check("rst_st_clear_cycles", TILE_W'(cyc), TILE_W'(32));
        do_read("rd16", 6'd16, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
